// File: rtl/spi_frame_commit_pkg.sv
// Shared definitions for the SPI servo frame path: FSM encoding, frame byte map,
// checksum seed and config bit positions.
package spi_servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int PWM0_LO = 0;
    localparam int PWM0_HI = 1;
    localparam int PWM1_LO = 2;
    localparam int PWM1_HI = 3;
    localparam int PWM2_LO = 4;
    localparam int PWM2_HI = 5;
    localparam int PWM3_LO = 6;
    localparam int PWM3_HI = 7;
    localparam int CFG_LO  = 8;
    localparam int CFG_HI  = 9;
    localparam int CHK     = 10;

    localparam logic [7:0] CHK_SEED  = 8'hA5;
    localparam int         ZPOL_BIT  = 7;
    localparam int         QTEST_BIT = 5;
    localparam logic [4:0] BCNT_MAX  = 5'd31;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_frame_commit_if.sv
// Byte-level link from the SPI shifter: select edges and received bytes.
interface spi_frame_commit_if;
    logic       ssel_start;
    logic       ssel_end;
    logic       byte_rx;
    logic [7:0] rx_data;

    modport master (output ssel_start, output ssel_end, output byte_rx, output rx_data);
    modport slave  (input  ssel_start, input  ssel_end, input  byte_rx, input  rx_data);
endinterface

// File: rtl/spi_frame_commit_watchdog.sv
// Link watchdog: counts clocks since the last good commit and latches a sticky trip.
module spi_link_watchdog #(
    parameter int WD_CYCLES = 2000000,
    parameter int WDW       = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic trip
);
    localparam logic [WDW-1:0] LAST = WDW'(WD_CYCLES - 1);

    logic [WDW-1:0] cnt_r;
    logic           trip_r;

    // Counter and sticky trip; clr takes priority so a commit beats a same-cycle trip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            trip_r <= 1'b1;
        end else if (clr) begin
            cnt_r  <= '0;
            trip_r <= 1'b0;
        end else if (!trip_r) begin
            if (cnt_r == LAST) begin
                trip_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + {{(WDW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign trip = trip_r;
endmodule

// File: rtl/spi_frame_commit.sv
// Collects SPI frame bytes into shadow registers and commits PWM/dout/config atomically
// once a complete, checksum-valid frame has ended.
module spi_frame_commit
    import spi_servo_pkg::*;
#(
    parameter int WD_CYCLES = 2000000,
    parameter int WDW       = 21,
    parameter int MIN_BYTES = 11,
    parameter bit CHK_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                nRESET,
    spi_frame_commit_if.slave   rx,
    output logic                snap,
    output logic [15:0]         pwm0,
    output logic [15:0]         pwm1,
    output logic [15:0]         pwm2,
    output logic [15:0]         pwm3,
    output logic [9:0]          dout,
    output logic                zpol,
    output logic                qtest,
    output logic                wd_trip,
    output logic                frame_ok,
    output logic [7:0]          good_cnt,
    output logic [7:0]          err_cnt
);
    localparam logic [4:0] MIN_B = 5'(MIN_BYTES);

    state_t      state_r;
    logic [4:0]  bcnt_r;
    logic [7:0]  chk_r;
    logic [7:0]  shadow_r [0:10];
    logic [15:0] pwm_r    [0:3];
    logic [9:0]  dout_r;
    logic        zpol_r;
    logic        qtest_r;
    logic        snap_r;
    logic        frame_ok_r;
    logic [7:0]  good_cnt_r;
    logic [7:0]  err_cnt_r;
    logic        frame_good_s;
    logic        commit_good_s;

    // Frame verdict uses only registered bcnt/chk, so a byte arriving with ssel_end is included.
    always_comb begin
        frame_good_s = 1'b0;
        if (bcnt_r >= MIN_B) begin
            frame_good_s = !CHK_EN || (shadow_r[CHK] == (chk_r ^ CHK_SEED));
        end else begin
            frame_good_s = 1'b0;
        end
        commit_good_s = (state_r == ST_COMMIT) && frame_good_s;
    end

    // Frame sequencer, shadow capture and atomic output commit.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_r    <= ST_IDLE;
            bcnt_r     <= 5'd0;
            chk_r      <= 8'h00;
            for (int i = 0; i < 11; i++) shadow_r[i] <= 8'h00;
            for (int i = 0; i < 4; i++)  pwm_r[i]    <= 16'h0000;
            dout_r     <= 10'h000;
            zpol_r     <= 1'b0;
            qtest_r    <= 1'b0;
            snap_r     <= 1'b0;
            frame_ok_r <= 1'b0;
            good_cnt_r <= 8'h00;
            err_cnt_r  <= 8'h00;
        end else begin
            snap_r     <= 1'b0;
            frame_ok_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx.ssel_start) begin
                        state_r <= ST_RECV;
                        bcnt_r  <= 5'd0;
                        chk_r   <= 8'h00;
                        snap_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (rx.ssel_start) begin
                        // Select re-asserted without an end: drop the partial frame.
                        err_cnt_r <= sat_inc8(err_cnt_r);
                        bcnt_r    <= 5'd0;
                        chk_r     <= 8'h00;
                        snap_r    <= 1'b1;
                    end else begin
                        if (rx.byte_rx) begin
                            if (bcnt_r <= 5'd10) shadow_r[bcnt_r[3:0]] <= rx.rx_data;
                            if (bcnt_r <= 5'd9)  chk_r <= chk_r ^ rx.rx_data;
                            if (bcnt_r != BCNT_MAX) bcnt_r <= bcnt_r + 5'd1;
                        end
                        if (rx.ssel_end) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            state_r <= ST_RECV;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                    if (frame_good_s) begin
                        pwm_r[0]   <= {shadow_r[PWM0_HI], shadow_r[PWM0_LO]};
                        pwm_r[1]   <= {shadow_r[PWM1_HI], shadow_r[PWM1_LO]};
                        pwm_r[2]   <= {shadow_r[PWM2_HI], shadow_r[PWM2_LO]};
                        pwm_r[3]   <= {shadow_r[PWM3_HI], shadow_r[PWM3_LO]};
                        dout_r     <= {shadow_r[CFG_HI][1:0], shadow_r[CFG_LO]};
                        zpol_r     <= shadow_r[CFG_HI][ZPOL_BIT];
                        qtest_r    <= shadow_r[CFG_HI][QTEST_BIT];
                        frame_ok_r <= 1'b1;
                        good_cnt_r <= good_cnt_r + 8'd1;
                    end else begin
                        err_cnt_r  <= sat_inc8(err_cnt_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    spi_link_watchdog #(
        .WD_CYCLES (WD_CYCLES),
        .WDW       (WDW)
    ) u_wdog (
        .clk   (clk),
        .rst_n (nRESET),
        .clr   (commit_good_s),
        .trip  (wd_trip)
    );

    // Tripped link forces every channel idle; committed words stay intact for recovery.
    assign pwm0     = wd_trip ? 16'h0000 : pwm_r[0];
    assign pwm1     = wd_trip ? 16'h0000 : pwm_r[1];
    assign pwm2     = wd_trip ? 16'h0000 : pwm_r[2];
    assign pwm3     = wd_trip ? 16'h0000 : pwm_r[3];
    assign dout     = dout_r;
    assign zpol     = zpol_r;
    assign qtest    = qtest_r;
    assign snap     = snap_r;
    assign frame_ok = frame_ok_r;
    assign good_cnt = good_cnt_r;
    assign err_cnt  = err_cnt_r;
endmodule

// File: tb/tb_spi_frame_commit.sv
// Directed self-checking bench for spi_frame_commit with a shortened watchdog.
module tb_spi_frame_commit;
    logic        clk = 1'b0;
    logic        nRESET;
    logic        snap, zpol, qtest, wd_trip, frame_ok;
    logic [15:0] pwm0, pwm1, pwm2, pwm3;
    logic [9:0]  dout;
    logic [7:0]  good_cnt, err_cnt;
    logic [7:0]  fb [0:19];
    logic        sn, ok;
    int          checks = 0;
    int          failures = 0;

    // Frame A: 34 12 00 80 FF 07 01 00 AA 83, chk D3 (byte 0 in the low bits).
    localparam logic [87:0] FRAME_A     = 88'hD3_83_AA_00_01_07_FF_80_00_12_34;
    // Frame B: 11 22 33 44 55 66 77 88 01 20, chk 0C.
    localparam logic [87:0] FRAME_B     = 88'h0C_20_01_88_77_66_55_44_33_22_11;
    localparam logic [87:0] FRAME_B_BAD = 88'h0D_20_01_88_77_66_55_44_33_22_11;

    spi_frame_commit_if rx_if ();

    spi_frame_commit #(
        .WD_CYCLES (100),
        .WDW       (21),
        .MIN_BYTES (11),
        .CHK_EN    (1'b1)
    ) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .rx       (rx_if),
        .snap     (snap),
        .pwm0     (pwm0),
        .pwm1     (pwm1),
        .pwm2     (pwm2),
        .pwm3     (pwm3),
        .dout     (dout),
        .zpol     (zpol),
        .qtest    (qtest),
        .wd_trip  (wd_trip),
        .frame_ok (frame_ok),
        .good_cnt (good_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [87:0] v);
        for (int i = 0; i < 11; i++) fb[i] = v[8*i +: 8];
    endtask

    task automatic send(input int n, input bit coincide, output logic snap_seen, output logic ok_seen);
        rx_if.ssel_start = 1'b1;
        step();
        rx_if.ssel_start = 1'b0;
        snap_seen = snap;
        for (int i = 0; i < n; i++) begin
            rx_if.rx_data = fb[i];
            rx_if.byte_rx = 1'b1;
            if (coincide && i == n - 1) rx_if.ssel_end = 1'b1;
            step();
            rx_if.byte_rx  = 1'b0;
            rx_if.ssel_end = 1'b0;
        end
        if (!(coincide && n > 0)) begin
            rx_if.ssel_end = 1'b1;
            step();
            rx_if.ssel_end = 1'b0;
        end
        step();
        ok_seen = frame_ok;
    endtask

    task automatic exp_out(input string tag, input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input logic [9:0] d, input logic z, input logic q);
        chk({tag, "_pwm0"}, {16'h0000, pwm0}, {16'h0000, p0});
        chk({tag, "_pwm1"}, {16'h0000, pwm1}, {16'h0000, p1});
        chk({tag, "_pwm2"}, {16'h0000, pwm2}, {16'h0000, p2});
        chk({tag, "_pwm3"}, {16'h0000, pwm3}, {16'h0000, p3});
        chk({tag, "_dout"}, {22'h000000, dout}, {22'h000000, d});
        chk({tag, "_zpol"}, {31'h0, zpol}, {31'h0, z});
        chk({tag, "_qtest"}, {31'h0, qtest}, {31'h0, q});
    endtask

    initial begin
        rx_if.ssel_start = 1'b0;
        rx_if.ssel_end   = 1'b0;
        rx_if.byte_rx    = 1'b0;
        rx_if.rx_data    = 8'h00;
        nRESET = 1'b0;
        for (int i = 0; i < 20; i++) fb[i] = 8'h00;
        repeat (3) step();

        exp_out("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 10'h000, 1'b0, 1'b0);
        chk("rst_wd_trip", {31'h0, wd_trip}, 32'd1);
        chk("rst_good", {24'h0, good_cnt}, 32'd0);
        chk("rst_err", {24'h0, err_cnt}, 32'd0);
        chk("rst_snap", {31'h0, snap}, 32'd0);
        nRESET = 1'b1;
        step();

        // Good frame A
        load(FRAME_A);
        send(11, 1'b0, sn, ok);
        chk("a_snap", {31'h0, sn}, 32'd1);
        chk("a_frame_ok", {31'h0, ok}, 32'd1);
        exp_out("a", 16'h1234, 16'h8000, 16'h07FF, 16'h0001, 10'h3AA, 1'b1, 1'b0);
        chk("a_good", {24'h0, good_cnt}, 32'd1);
        chk("a_wd_trip", {31'h0, wd_trip}, 32'd0);
        step();
        chk("a_frame_ok_pulse", {31'h0, frame_ok}, 32'd0);

        // Bad checksum, then a 10-byte frame: nothing moves
        load(FRAME_B_BAD);
        send(11, 1'b0, sn, ok);
        chk("badchk_frame_ok", {31'h0, ok}, 32'd0);
        chk("badchk_err", {24'h0, err_cnt}, 32'd1);
        exp_out("badchk", 16'h1234, 16'h8000, 16'h07FF, 16'h0001, 10'h3AA, 1'b1, 1'b0);
        load(FRAME_B);
        send(10, 1'b0, sn, ok);
        chk("short_frame_ok", {31'h0, ok}, 32'd0);
        chk("short_err", {24'h0, err_cnt}, 32'd2);
        chk("short_good", {24'h0, good_cnt}, 32'd1);
        exp_out("short", 16'h1234, 16'h8000, 16'h07FF, 16'h0001, 10'h3AA, 1'b1, 1'b0);

        // Abort after 5 bytes, restart straight into frame B
        rx_if.ssel_start = 1'b1;
        step();
        rx_if.ssel_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_if.rx_data = fb[i];
            rx_if.byte_rx = 1'b1;
            step();
            rx_if.byte_rx = 1'b0;
        end
        send(11, 1'b0, sn, ok);
        chk("abort_snap", {31'h0, sn}, 32'd1);
        chk("abort_err", {24'h0, err_cnt}, 32'd3);
        chk("abort_frame_ok", {31'h0, ok}, 32'd1);
        chk("abort_good", {24'h0, good_cnt}, 32'd2);
        exp_out("b", 16'h2211, 16'h4433, 16'h6655, 16'h8877, 10'h001, 1'b0, 1'b1);

        // Watchdog: 100 clocks of silence after the commit trips it
        repeat (99) step();
        chk("wd_before", {31'h0, wd_trip}, 32'd0);
        step();
        chk("wd_after", {31'h0, wd_trip}, 32'd1);
        exp_out("wd", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 10'h001, 1'b0, 1'b1);
        load(FRAME_A);
        send(11, 1'b0, sn, ok);
        chk("wd_recover_ok", {31'h0, ok}, 32'd1);
        chk("wd_recover_trip", {31'h0, wd_trip}, 32'd0);
        exp_out("wd_rec", 16'h1234, 16'h8000, 16'h07FF, 16'h0001, 10'h3AA, 1'b1, 1'b0);
        chk("wd_recover_good", {24'h0, good_cnt}, 32'd3);

        // Last byte coincident with ssel_end
        load(FRAME_B);
        send(11, 1'b1, sn, ok);
        chk("coinc_frame_ok", {31'h0, ok}, 32'd1);
        exp_out("coinc", 16'h2211, 16'h4433, 16'h6655, 16'h8877, 10'h001, 1'b0, 1'b1);
        chk("coinc_good", {24'h0, good_cnt}, 32'd4);

        // 20-byte frame: trailing bytes ignored
        load(FRAME_A);
        for (int i = 11; i < 20; i++) fb[i] = 8'hFF;
        send(20, 1'b0, sn, ok);
        chk("long_frame_ok", {31'h0, ok}, 32'd1);
        exp_out("long", 16'h1234, 16'h8000, 16'h07FF, 16'h0001, 10'h3AA, 1'b1, 1'b0);
        chk("long_good", {24'h0, good_cnt}, 32'd5);

        // Reset in the middle of a frame
        load(FRAME_B);
        rx_if.ssel_start = 1'b1;
        step();
        rx_if.ssel_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_if.rx_data = fb[i];
            rx_if.byte_rx = 1'b1;
            step();
            rx_if.byte_rx = 1'b0;
        end
        nRESET = 1'b0;
        #2;
        exp_out("midrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 10'h000, 1'b0, 1'b0);
        chk("midrst_wd", {31'h0, wd_trip}, 32'd1);
        chk("midrst_good", {24'h0, good_cnt}, 32'd0);
        chk("midrst_err", {24'h0, err_cnt}, 32'd0);
        step();
        nRESET = 1'b1;
        step();
        send(11, 1'b0, sn, ok);
        chk("midrst_next_ok", {31'h0, ok}, 32'd1);
        exp_out("midrst_b", 16'h2211, 16'h4433, 16'h6655, 16'h8877, 10'h001, 1'b0, 1'b1);
        chk("midrst_next_good", {24'h0, good_cnt}, 32'd1);

        // good_cnt wraps
        for (int i = 0; i < 254; i++) send(11, 1'b0, sn, ok);
        chk("good_255", {24'h0, good_cnt}, 32'd255);
        send(11, 1'b0, sn, ok);
        chk("good_wrap_ok", {31'h0, ok}, 32'd1);
        chk("good_wrap", {24'h0, good_cnt}, 32'd0);

        // err_cnt saturates, using empty frames
        for (int i = 0; i < 255; i++) send(0, 1'b0, sn, ok);
        chk("err_255", {24'h0, err_cnt}, 32'd255);
        send(0, 1'b0, sn, ok);
        chk("err_sat_ok", {31'h0, ok}, 32'd0);
        chk("err_sat", {24'h0, err_cnt}, 32'd255);
        chk("err_sat_good", {24'h0, good_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
